an_encoder_seq: RTL and testbench
=================================

Name: an_encoder_seq

Overview:
Sequential AN-code encoder; the transmit-side counterpart of the AN decoder.
- Takes an N_W-bit data word N and produces the codeword ANc = A*N on AN_W bits.
- The multiply is an iterative shift-and-add over the bits of the constant A, one bit per cycle.
- Valid/ready handshakes on both sides.
- Sits between the data producer and the storage/channel that the AN decoder later reads (default A=13, N 8-bit, AN 12-bit).

Parameters:
- A, 13, code constant; odd, >= 3.
- N_W, 8, data word width.
- AN_W, 12, codeword width; must satisfy AN_W >= N_W + A_W.
- A_W, derived localparam = $clog2(A+1) (4 for A=13); number of multiply steps.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  N is valid
- in_ready  output  1  block can accept N
- N  input  N_W  data word to encode
- out_valid  output  1  ANc is valid
- out_ready  input  1  consumer accepts ANc
- ANc  output  AN_W  encoded codeword A*N
- busy  output  1  high while in state MUL or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, cnt=0, n_reg=0.
  - Outputs: in_ready=1, out_valid=0, ANc=0, busy=0.
  - Reset takes effect immediately, including mid-MUL or in DONE; any in-flight word is discarded and no partial result is ever presented.
- FSM states IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid&&in_ready: n_reg<=N, acc<=0, cnt<=0, go to MUL.
  - Without in_valid, stay in IDLE.
- MUL:
  - in_ready=0, busy=1.
  - Each cycle: if A[cnt]==1 then acc <= acc + (n_reg << cnt); cnt <= cnt+1.
  - The shift and add are done at AN_W width with no overflow, guaranteed by the AN_W rule.
  - After the step with cnt==A_W-1, go to DONE.
  - Exactly A_W cycles in MUL.
- DONE:
  - out_valid=1 and ANc=acc; ANc is registered and stable while out_valid=1.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - out_ready=0 holds DONE indefinitely, with ANc unchanged.
- Latency: input accepted at edge k -> out_valid=1 after edge k+A_W (k+4 for the defaults).
- Throughput: one word per A_W+2 cycles when out_ready is held 1; in_ready returns the cycle after the output handshake.
- in_valid while in_ready=0: ignored, and N is not sampled. The producer must hold in_valid/N until it sees in_ready.
- ANc is 0 whenever out_valid=0 in IDLE after reset. In IDLE after a completed transfer, ANc keeps its last value; it is don't-care when out_valid=0.
- Invariant: every presented ANc satisfies ANc % A == 0 and ANc / A == the accepted N.
- Elaboration must fail (generate-time error) if AN_W < N_W + A_W or A is even.

Test Plan:
- N=0x00, out_ready=1 -> out_valid after 4 cycles, ANc=0x000; in_ready back 1 cycle after the output handshake.
- N=0x01 -> ANc=0x00D.
- N=0xFF -> ANc=0xCF3 (3315).
- N=0x5A -> ANc=0x492 (1170); ANc%13==0.
- Backpressure: N=0x10, out_ready=0 for 10 cycles -> out_valid stays 1 and ANc=0x0D0 stable; in_valid pulses with N=0x22 during this time are not accepted (in_ready=0). Then out_ready=1 -> one transfer, return to IDLE.
- Reset mid-operation: accept N=0x37, assert rst during the 2nd MUL cycle -> out_valid=0, ANc=0, in_ready=1 immediately. After rst deasserts, N=0x02 yields ANc=0x01A with no trace of 0x37.
- Random: 1000 words with random in_valid/out_ready gaps -> every ANc == 13*N, in order, with no drops or duplicates (scoreboard; optionally loop through the AN decoder and check Nc==N).

Source files
------------

// File: rtl/an_encoder_seq.sv
// an_encoder_seq: sequential AN-code encoder producing ANc = A*N
// by one shift-and-add step per bit of the constant A.
module an_encoder_seq #(
    parameter int A    = 13,
    parameter int N_W  = 8,
    parameter int AN_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_W-1:0]  N,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AN_W-1:0] ANc,
    output logic            busy
);
    localparam int A_W = $clog2(A + 1);
    localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [A_W-1:0] A_BITS = A_W'(A);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(A_W - 1);

    if (AN_W < N_W + A_W) begin : g_bad_width
        $error("an_encoder_seq: AN_W must be >= N_W + A_W");
    end
    if ((A % 2) == 0 || A < 3) begin : g_bad_a
        $error("an_encoder_seq: A must be odd and >= 3");
    end

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [AN_W-1:0]  acc;
    logic [AN_W-1:0]  res;
    logic [AN_W-1:0]  addend;
    logic [AN_W-1:0]  sum;
    logic [CNT_W-1:0] cnt;
    logic [N_W-1:0]   n_reg;

    // One partial product per cycle, selected by the current bit of A.
    assign addend = AN_W'(n_reg) << cnt;
    assign sum    = acc + (A_BITS[cnt] ? addend : '0);
    assign ANc    = res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The result register is loaded only from the final step, so a
    // partial product never reaches ANc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            n_reg <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_reg <= N;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        res <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_an_encoder_seq.sv
// Directed and randomized-gap checks of an_encoder_seq with
// immediate assertions against hand-computed codewords.
module tb_an_encoder_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  N;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] ANc;
    logic        busy;

    int vec;
    int errs;

    an_encoder_seq #(
        .A   (13),
        .N_W (8),
        .AN_W(12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .N        (N),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ANc      (ANc),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word with out_ready=1 and check latency, value and
    // the return of in_ready right after the output handshake.
    task automatic xfer(input logic [7:0] n, input logic [11:0] exp,
                        input string tag);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        N         = n;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_anc"}, ANc, exp);
        chk({tag, "_mod13"}, ANc % 13, 0);
        tick();
        chk({tag, "_drop_valid"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        int sent;
        int got;
        int cyc;
        bit acc_in;
        bit acc_out;
        bit seen;
        logic [11:0] q[$];
        logic [11:0] e;

        vec       = 0;
        errs      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        N         = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_anc", ANc, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        xfer(8'h00, 12'h000, "n00");
        xfer(8'h01, 12'h00D, "n01");
        xfer(8'hFF, 12'hCF3, "nFF");
        xfer(8'h5A, 12'h492, "n5A");

        // Backpressure with ignored input pulses.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        N         = 8'h10;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2) == 0;
            N        = 8'h22;
            chk("bp_valid", out_valid, 1);
            chk("bp_anc", ANc, 12'h0D0);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_anc_end", ANc, 12'h0D0);
        out_ready = 1'b1;
        tick();
        chk("bp_drop_valid", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("bp_no_ghost", seen, 0);

        // Asynchronous reset during the second MUL cycle.
        in_valid = 1'b1;
        N        = 8'h37;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_anc", ANc, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        xfer(8'h02, 12'h01A, "n02");

        // Random gaps on both sides with an in-order scoreboard.
        sent     = 0;
        got      = 0;
        cyc      = 0;
        in_valid = 1'b0;
        while (got < 1000 && cyc < 40000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                N        = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc_in    = in_valid && in_ready;
            acc_out   = out_valid && out_ready;
            if (acc_out) begin
                if (q.size() == 0) begin
                    chk("rand_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rand_anc", ANc, e);
                end
                got++;
            end
            if (acc_in) begin
                q.push_back(12'(13 * N));
                sent++;
            end
            tick();
            cyc++;
            if (acc_in) in_valid = 1'b0;
        end
        chk("rand_count", got, 1000);
        chk("rand_leftover", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
